// File: rtl/clint_master_pkg.sv
// Shared CLINT definitions: address map, bus width and FSM state encodings
// for the CLINT bus master and its interrupt controller.
package clint_master_pkg;

    localparam int WORD_BUS = 64;

    localparam logic [WORD_BUS-1:0] CLINT_BASE    = 64'h0000_0000_0200_0000;
    localparam logic [WORD_BUS-1:0] CLINT_MASK    = 64'hFFFF_FFFF_FFFF_0000;
    localparam logic [WORD_BUS-1:0] MTIME_ADDR    = 64'h0000_0000_0200_BFF8;
    localparam logic [WORD_BUS-1:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_CAP   = 3'd2,
        WR_ISSUE = 3'd3,
        WR_WAIT  = 3'd4,
        RESP     = 3'd5
    } bus_state_t;

    typedef enum logic [1:0] {
        I_IDLE = 2'd0,
        I_PEND = 2'd1,
        I_ACK  = 2'd2,
        I_HOLD = 2'd3
    } irq_state_t;

    typedef enum logic [1:0] {
        ADDR_MTIME    = 2'd0,
        ADDR_MTIMECMP = 2'd1,
        ADDR_BAD      = 2'd2
    } addr_kind_t;

    // Anything that is not one of the two implemented registers is answered
    // with an error, whether it falls inside the CLINT window or not.
    function automatic addr_kind_t decode_addr(input logic [WORD_BUS-1:0] addr);
        if ((addr & CLINT_MASK) != CLINT_BASE) return ADDR_BAD;
        if (addr == MTIME_ADDR)                return ADDR_MTIME;
        if (addr == MTIMECMP_ADDR)             return ADDR_MTIMECMP;
        return ADDR_BAD;
    endfunction

endpackage

// File: rtl/clint_master_if.sv
// MMIO request/response bus between the CPU side (master) and the CLINT
// bus master (slave).
interface clint_master_if;

    logic                                  req_valid;
    logic                                  req_we;
    logic [clint_master_pkg::WORD_BUS-1:0] req_addr;
    logic [clint_master_pkg::WORD_BUS-1:0] req_wdata;
    logic                                  req_ready;
    logic                                  resp_valid;
    logic [clint_master_pkg::WORD_BUS-1:0] resp_rdata;
    logic                                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/clint_irq_ctrl.sv
// Timer interrupt handshake: raises a trap request while enabled, acknowledges
// the CLINT once the trap is taken, then waits for the level to clear.
module clint_irq_ctrl
    import clint_master_pkg::*;
(
    input  logic cpu_clk_50M,
    input  logic cpu_rst_n,
    input  logic interr,
    input  logic mstatus_mie,
    input  logic mie_mtie,
    input  logic trap_taken,
    output logic timer_irq_req,
    output logic interr_isdone
);

    irq_state_t state;
    irq_state_t state_next;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) state <= I_IDLE;
        else            state <= state_next;
    end

    // trap_taken wins over a same-cycle enable drop: the CSR has already trapped.
    always_comb begin
        state_next    = state;
        timer_irq_req = 1'b0;
        interr_isdone = 1'b0;
        unique case (state)
            I_IDLE: if (interr && mstatus_mie && mie_mtie) state_next = I_PEND;
            I_PEND: begin
                timer_irq_req = 1'b1;
                if (trap_taken)                     state_next = I_ACK;
                else if (!(mstatus_mie && mie_mtie)) state_next = I_IDLE;
            end
            I_ACK: begin
                interr_isdone = 1'b1;
                state_next    = I_HOLD;
            end
            I_HOLD: if (!interr) state_next = I_IDLE;
            default: state_next = I_IDLE;
        endcase
    end

endmodule

// File: rtl/clint_master.sv
// CLINT bus master: turns single MMIO requests into one-cycle CLINT read/write
// strobes with a one-cycle response, and hosts the timer interrupt controller.
module clint_master
    import clint_master_pkg::*;
#(
    parameter int unsigned WR_TIMEOUT = 15
) (
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst_n,
    clint_master_if.slave       bus,
    output logic                read_en,
    output logic [WORD_BUS-1:0] read_addr,
    input  logic [WORD_BUS-1:0] data_read,
    output logic                write_en,
    output logic [WORD_BUS-1:0] write_addr,
    output logic [WORD_BUS-1:0] data_write,
    input  logic                clint_write_isdone,
    input  logic                interr,
    output logic                interr_isdone,
    input  logic                mstatus_mie,
    input  logic                mie_mtie,
    input  logic                trap_taken,
    output logic                timer_irq_req
);

    localparam int CNT_W = $clog2(WR_TIMEOUT + 1);

    bus_state_t          state;
    bus_state_t          state_next;
    addr_kind_t          kind_q;
    addr_kind_t          req_kind;
    logic [WORD_BUS-1:0] addr_q;
    logic [WORD_BUS-1:0] wdata_q;
    logic [WORD_BUS-1:0] rdata_q;
    logic                err_q;
    logic                ready_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic                accept;
    logic                wait_expired;

    assign req_kind     = decode_addr(bus.req_addr);
    // ready_q keeps req_ready low while reset is held, rising on the first edge after release.
    assign accept       = (state == IDLE) && ready_q && bus.req_valid;
    assign wait_expired = (wait_cnt == CNT_W'(WR_TIMEOUT - 1));

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) state <= IDLE;
        else            state <= state_next;
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            ready_q  <= 1'b0;
            kind_q   <= ADDR_BAD;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            ready_q <= 1'b1;
            unique case (state)
                IDLE: if (accept) begin
                    kind_q  <= req_kind;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    rdata_q <= '0;
                    err_q   <= (req_kind == ADDR_BAD);
                end
                RD_CAP:   rdata_q  <= data_read;
                WR_ISSUE: wait_cnt <= '0;
                WR_WAIT: if (!clint_write_isdone) begin
                    if (wait_expired) err_q    <= 1'b1;
                    else              wait_cnt <= wait_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Only MTIMECMP writes need the CLINT's completion; MTIME writes finish at once.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) begin
                if (req_kind == ADDR_BAD) state_next = RESP;
                else if (bus.req_we)      state_next = WR_ISSUE;
                else                      state_next = RD_ISSUE;
            end
            RD_ISSUE: state_next = RD_CAP;
            RD_CAP:   state_next = RESP;
            WR_ISSUE: state_next = (kind_q == ADDR_MTIMECMP) ? WR_WAIT : RESP;
            WR_WAIT:  if (clint_write_isdone || wait_expired) state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = '0;
        read_en        = 1'b0;
        read_addr      = '0;
        write_en       = 1'b0;
        write_addr     = '0;
        data_write     = '0;
        unique case (state)
            IDLE: bus.req_ready = ready_q;
            RD_ISSUE: begin
                read_en   = 1'b1;
                read_addr = addr_q;
            end
            WR_ISSUE: begin
                write_en   = 1'b1;
                write_addr = addr_q;
                data_write = wdata_q;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = rdata_q;
            end
            default: ;
        endcase
    end

    clint_irq_ctrl u_irq_ctrl (
        .cpu_clk_50M   (cpu_clk_50M),
        .cpu_rst_n     (cpu_rst_n),
        .interr        (interr),
        .mstatus_mie   (mstatus_mie),
        .mie_mtie      (mie_mtie),
        .trap_taken    (trap_taken),
        .timer_irq_req (timer_irq_req),
        .interr_isdone (interr_isdone)
    );

endmodule
